// File: rtl/max7317_responder_pkg.sv
// Shared constants, FSM state type and command decode helpers for the
// MAX7317 responder emulation.
package max7317_pkg;

  localparam int NUM_PORTS  = 10;
  localparam int FRAME_BITS = 16;

  localparam logic [6:0] CMD_WR_ALL = 7'h0A;
  localparam logic [6:0] CMD_WR_P30 = 7'h0B;
  localparam logic [6:0] CMD_WR_P74 = 7'h0C;
  localparam logic [6:0] CMD_RD_P70 = 7'h0E;
  localparam logic [6:0] CMD_RD_P98 = 7'h0F;
  localparam logic [6:0] CMD_NOP    = 7'h20;

  localparam logic [4:0] BIT_CNT_SAT = 5'd17;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, WAIT_CS} state_e;

  // New port latch after a committed frame; reads and unknown addresses keep it.
  function automatic logic [NUM_PORTS-1:0] apply_write(
    input logic [NUM_PORTS-1:0] ports,
    input logic                 is_read,
    input logic [6:0]           addr,
    input logic                 d0
  );
    logic [NUM_PORTS-1:0] p;
    p = ports;
    if (!is_read) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (addr == 7'(i)) p[i] = d0;
      end
      case (addr)
        CMD_WR_ALL: p      = {NUM_PORTS{d0}};
        CMD_WR_P30: p[3:0] = {4{d0}};
        CMD_WR_P74: p[7:4] = {4{d0}};
        default:    ;
      endcase
    end
    return p;
  endfunction

  // Word returned on MISO during the next frame.
  function automatic logic [FRAME_BITS-1:0] resp_for(
    input logic [FRAME_BITS-1:0] frame,
    input logic [NUM_PORTS-1:0]  pins
  );
    logic [FRAME_BITS-1:0] r;
    r = frame;
    if (frame[15:8] == {1'b1, CMD_RD_P70}) begin
      r = {frame[15:8], pins[7:0]};
    end else if (frame[15:8] == {1'b1, CMD_RD_P98}) begin
      r = {frame[15:8], 6'b0, pins[9:8]};
    end else if (frame[15]) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (frame[14:8] == 7'(i)) r = {frame[15:8], 7'b0, pins[i]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/max7317_responder_if.sv
// SPI pin bundle between the board initiator and the responder.
interface max7317_responder_if;
  logic sclk;
  logic CSn;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, output CSn, output mosi, input miso, input miso_oe);
  modport slave  (input sclk, input CSn, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/max7317_responder_sync_edge.sv
// Two-flop synchronizer with one-cycle rise/fall pulses derived from a
// third (edge-detect) register.
module sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], d};
    prev_d = sync_q[1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {2{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~prev_q;
  assign fall  = ~sync_q[1] & prev_q;

endmodule

// File: rtl/max7317_responder.sv
// MAX7317 10-port expander emulation: SPI responder, port latch, read-back.
// Optional frame/error counters: define MAX7317_RSP_STATS_EN.
module max7317_responder
  import max7317_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  max7317_responder_if.slave    spi,
  input  logic [NUM_PORTS-1:0]  port_in,
  output logic [NUM_PORTS-1:0]  port_out,
  output logic                  frame_valid,
  output logic [FRAME_BITS-1:0] frame_word,
  output logic                  frame_err,
  output logic [7:0]            frame_count,
  output logic [7:0]            err_count
);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  // CSn resets to "selected" so a frame already in flight at reset release is waited out.
  sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk, .reset, .d(spi.sclk), .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall));
  sync_edge #(.RESET_VAL(1'b0)) u_sync_csn (
    .clk, .reset, .d(spi.CSn), .level(cs_level), .rise(cs_rise), .fall(cs_fall));
  sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk, .reset, .d(spi.mosi), .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic                  miso_q, miso_d;
  logic                  miso_oe_q, miso_oe_d;
  logic [NUM_PORTS-1:0]  port_out_q, port_out_d;
  logic [FRAME_BITS-1:0] resp_word_q, resp_word_d;
  logic [FRAME_BITS-1:0] frame_word_q, frame_word_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  frame_err_q, frame_err_d;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d       = state_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    bit_cnt_d     = bit_cnt_q;
    miso_d        = miso_q;
    port_out_d    = port_out_q;
    resp_word_d   = resp_word_q;
    frame_word_d  = frame_word_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    // Not driven while an inherited partial frame is being waited out.
    miso_oe_d     = ~cs_level & (state_q != WAIT_CS);

    case (state_q)
      IDLE: begin
        if (cs_fall && !cs_rise) begin
          tx_shift_d = resp_word_q;
          miso_d     = resp_word_q[15];
          bit_cnt_d  = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          if (bit_cnt_q == 5'(FRAME_BITS)) begin
            state_d = COMMIT;
          end else begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end
        end else begin
          if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[FRAME_BITS-2:0], mosi_level};
            if (bit_cnt_q != BIT_CNT_SAT) bit_cnt_d = bit_cnt_q + 5'd1;
          end
          // Zeros shift in behind the data, so miso idles low after bit 0.
          if (sclk_fall) begin
            miso_d     = tx_shift_q[FRAME_BITS-2];
            tx_shift_d = {tx_shift_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      COMMIT: begin
        port_out_d    = apply_write(port_out_q, rx_shift_q[15], rx_shift_q[14:8], rx_shift_q[0]);
        resp_word_d   = resp_for(rx_shift_q, port_in);
        frame_word_d  = rx_shift_q;
        frame_valid_d = 1'b1;
        state_d       = IDLE;
      end
      WAIT_CS: begin
        if (cs_level) state_d = IDLE;
      end
      default: state_d = WAIT_CS;
    endcase
  end

  // NOTE: sequential state is written with <= only, so all flops see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= WAIT_CS;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      bit_cnt_q     <= '0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      port_out_q    <= {NUM_PORTS{1'b1}};
      resp_word_q   <= '0;
      frame_word_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      bit_cnt_q     <= bit_cnt_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      port_out_q    <= port_out_d;
      resp_word_q   <= resp_word_d;
      frame_word_q  <= frame_word_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign spi.miso     = miso_q;
  assign spi.miso_oe  = miso_oe_q;
  assign port_out     = port_out_q;
  assign frame_word   = frame_word_q;
  assign frame_valid  = frame_valid_q;
  assign frame_err    = frame_err_q;

`ifdef MAX7317_RSP_STATS_EN
  logic [7:0] frame_count_q, frame_count_d;
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    frame_count_d = frame_count_q;
    err_count_d   = err_count_q;
    if (frame_valid_q) frame_count_d = frame_count_q + 8'd1;
    if (frame_err_q && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count_q <= 8'h00;
      err_count_q   <= 8'h00;
    end else begin
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;
`else
  assign frame_count = 8'h00;
  assign err_count   = 8'h00;
`endif

endmodule

// File: tb/tb_max7317_responder.sv
// Randomized and directed bench for max7317_responder against a behavioural
// model of the expander protocol.
module tb_max7317_responder;
  import max7317_pkg::*;

`ifdef MAX7317_RSP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [9:0]  port_in;
  logic [9:0]  port_out;
  logic        frame_valid;
  logic [15:0] frame_word;
  logic        frame_err;
  logic [7:0]  frame_count;
  logic [7:0]  err_count;

  max7317_responder_if spi ();

  max7317_responder dut (
    .clk         (clk),
    .reset       (reset),
    .spi         (spi),
    .port_in     (port_in),
    .port_out    (port_out),
    .frame_valid (frame_valid),
    .frame_word  (frame_word),
    .frame_err   (frame_err),
    .frame_count (frame_count),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;
  int n_err    = 0;

  always @(negedge clk) begin
    if (frame_valid) n_valid++;
    if (frame_err)   n_err++;
  end

  // Behavioural model of the expander as seen from the bus.
  logic [9:0]  m_port;
  logic [15:0] m_resp;
  logic [15:0] m_fword;
  int          m_fcnt;
  int          m_ecnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_commit(input logic [15:0] frame, input logic [9:0] pins);
    int rw, addr, d0, hi;
    rw   = int'(frame) / 32768;
    addr = (int'(frame) / 256) % 128;
    hi   = int'(frame) / 256;
    d0   = int'(frame) % 2;
    if (rw == 0) begin
      if (addr <= 9)        m_port[addr] = d0[0];
      else if (addr == 10)  m_port = (d0 != 0) ? 10'h3FF : 10'h000;
      else if (addr == 11)  for (int i = 0; i < 4; i++) m_port[i] = d0[0];
      else if (addr == 12)  for (int i = 4; i < 8; i++) m_port[i] = d0[0];
    end
    if (hi == 'h8E)                   m_resp = 16'(32'h8E00 + (int'(pins) % 256));
    else if (hi == 'h8F)              m_resp = 16'(32'h8F00 + (int'(pins) / 256));
    else if (rw == 1 && addr <= 9)    m_resp = 16'(hi * 256 + ((int'(pins) >> addr) % 2));
    else                              m_resp = frame;
    m_fword = frame;
    m_fcnt  = (m_fcnt + 1) % 256;
  endtask

  task automatic model_abort();
    m_ecnt = (m_ecnt < 255) ? m_ecnt + 1 : 255;
  endtask

  task automatic do_reset(input logic cs_level);
    reset    = 1'b1;
    spi.CSn  = cs_level;
    spi.sclk = 1'b0;
    spi.mosi = 1'b0;
    repeat (20) @(negedge clk);
    m_port = 10'h3FF; m_resp = 16'h0000; m_fword = 16'h0000; m_fcnt = 0; m_ecnt = 0;
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Mode-0 transfer at SCLK = clk/4; miso is sampled at the end of each high phase.
  task automatic spi_xfer(input logic [15:0] tx, input int nbits, input int gap,
                          output logic [15:0] rx, output int v_at, output int e_at,
                          output logic oe);
    rx = '0; v_at = 0; e_at = 0; oe = 1'b0;
    spi.mosi = tx[15];
    spi.CSn  = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi.sclk = 1'b1;
      repeat (2) @(negedge clk);
      rx[15-i] = spi.miso;
      if (i == 0) oe = spi.miso_oe;
      spi.sclk = 1'b0;
      if (i < 15) spi.mosi = tx[14-i];
      repeat (2) @(negedge clk);
    end
    spi.CSn = 1'b1;
    for (int w = 1; w <= gap; w++) begin
      @(negedge clk);
      if (frame_valid && v_at == 0) v_at = w;
      if (frame_err && e_at == 0)   e_at = w;
    end
  endtask

  task automatic do_frame(input string tag, input logic [15:0] frame, input int nbits,
                          output logic [15:0] rx);
    logic [15:0] exp_miso;
    int          v_at, e_at;
    logic        oe;
    exp_miso = m_resp;
    spi_xfer(frame, nbits, 6, rx, v_at, e_at, oe);
    if (nbits == 16) begin
      model_commit(frame, port_in);
      check({tag, ".miso"},      32'(rx), 32'(exp_miso));
      check({tag, ".oe"},        32'(oe), 32'd1);
      check({tag, ".valid_lat"}, 32'(v_at), 32'd4);
      check({tag, ".no_err"},    32'(e_at), 32'd0);
    end else begin
      model_abort();
      check({tag, ".err_lat"},   32'(e_at), 32'd3);
      check({tag, ".no_valid"},  32'(v_at), 32'd0);
    end
    check({tag, ".oe_idle"},     32'(spi.miso_oe), 32'd0);
    check({tag, ".port_out"},    32'(port_out), 32'(m_port));
    check({tag, ".frame_word"},  32'(frame_word), 32'(m_fword));
    check({tag, ".frame_count"}, 32'(frame_count), STATS ? 32'(m_fcnt) : 32'd0);
    check({tag, ".err_count"},   32'(err_count), STATS ? 32'(m_ecnt) : 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rx;
    int          v_at, e_at, base_valid, base_err;
    logic        oe;

    port_in = 10'h000;

    // Reset held with CSn low, then a frame already in flight at release.
    reset = 1'b1; spi.CSn = 1'b0; spi.sclk = 1'b0; spi.mosi = 1'b0;
    repeat (20) @(negedge clk);
    check("rst.port_out",    32'(port_out), 32'h3FF);
    check("rst.miso_oe",     32'(spi.miso_oe), 32'd0);
    check("rst.miso",        32'(spi.miso), 32'd0);
    check("rst.frame_word",  32'(frame_word), 32'h0);
    check("rst.no_valid",    32'(n_valid), 32'd0);
    check("rst.frame_count", 32'(frame_count), 32'd0);
    check("rst.err_count",   32'(err_count), 32'd0);
    m_port = 10'h3FF; m_resp = 16'h0000; m_fword = 16'h0000; m_fcnt = 0; m_ecnt = 0;
    reset = 1'b0;
    spi_xfer(16'h0A00, 16, 6, rx, v_at, e_at, oe);
    check("wait_cs.no_valid", 32'(n_valid), 32'd0);
    check("wait_cs.no_err",   32'(n_err), 32'd0);
    check("wait_cs.port_out", 32'(port_out), 32'h3FF);

    // Configuration echo.
    do_frame("echo0", 16'h0A00, 16, rx);
    do_frame("echo1", 16'h2000, 16, rx);
    check("echo.port_out", 32'(port_out), 32'h000);
    check("echo.miso",     32'(rx), 32'h0A00);

    // Port reads.
    port_in = 10'h2A5;
    do_frame("rd70", 16'h8E00, 16, rx);
    do_frame("rd98", 16'h8F00, 16, rx);
    check("rd70.miso", 32'(rx), 32'h8EA5);
    do_frame("rdnop", 16'h2000, 16, rx);
    check("rd98.miso", 32'(rx), 32'h8F02);

    // Group writes from reset.
    do_reset(1'b1);
    do_frame("grp30", 16'h0B00, 16, rx);
    do_frame("grp74", 16'h0C01, 16, rx);
    check("grp.port_out", 32'(port_out), 32'h3F0);
    do_frame("grp5",  16'h0502, 16, rx);
    check("grp5.port_out", 32'(port_out), 32'h3D0);

    // Short frame: aborted, next frame echoes the previous committed word.
    do_frame("short", 16'h0A00, 9, rx);
    check("short.port_out", 32'(port_out), 32'h3D0);
    do_frame("after_short", 16'h2000, 16, rx);
    check("after_short.miso", 32'(rx), 32'h0502);

    // Randomized frames, addresses biased towards decoded commands.
    for (int n = 0; n < 60; n++) begin
      int          sel, addr, nb;
      logic [15:0] f;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0:       addr = int'($urandom_range(0, 9));
        1:       addr = int'($urandom_range(10, 12));
        2:       addr = int'($urandom_range(14, 15));
        3:       addr = 'h20;
        default: addr = int'($urandom_range(0, 127));
      endcase
      f = {1'($urandom_range(0, 1)), 7'(addr), 8'($urandom)};
      port_in = 10'($urandom);
      nb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : 16;
      do_frame("rand", f, nb, rx);
    end

    // Maximum rate: back-to-back NOPs with minimum CSn-high time.
    do_reset(1'b1);
    base_valid = n_valid;
    base_err   = n_err;
    for (int n = 0; n < 256; n++) begin
      logic [15:0] exp_miso;
      exp_miso = m_resp;
      spi_xfer(16'h2000, 16, 2, rx, v_at, e_at, oe);
      model_commit(16'h2000, port_in);
      check("maxrate.miso", 32'(rx), 32'(exp_miso));
    end
    repeat (6) @(negedge clk);
    check("maxrate.commits",     32'(n_valid - base_valid), 32'd256);
    check("maxrate.no_err",      32'(n_err - base_err), 32'd0);
    check("maxrate.frame_count", 32'(frame_count), 32'h00);
    check("maxrate.port_out",    32'(port_out), 32'h3FF);
    check("maxrate.frame_word",  32'(frame_word), 32'h2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
